sram_rw_port_ctrl: RTL and testbench

//   Request-side controller for the 256x96 single-port masked SRAM macro (RW0_* port, 24-bit mask granules).
//   - Request side: valid/ready, read or masked write.
//   - Drives the macro's RW0 port.
//   - Absorbs the macro's 1-cycle read latency into a response FIFO, so read data returns over valid/ready with backpressure.
//   - Sits directly upstream of the macro; the macro's RW0_clk is tied to clock.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_rsp_fifo.sv | 85 ++++++++
 rtl/sram_rsp_fifo_chk.sv | 19 +
 rtl/sram_rw_port_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the 256x96 masked single-port SRAM controller.
package sram_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 96;
  localparam int GRAN_W = 24;
  localparam int MASK_W = DATA_W / GRAN_W;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } init_state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO, DEPTH x WIDTH, synchronous active-low reset; storage itself is not reset.
module sram_rsp_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 96,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  sram_rsp_fifo_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .count   (count_q)
  );

endmodule

// File: rtl/sram_rsp_fifo_chk.sv
// Protocol checks for the read-response FIFO: no push into a full FIFO, no pop from an empty one.
module sram_rsp_fifo_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             clock,
  input logic             reset_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  push_when_full_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && (count == CNT_W'(DEPTH))));

  pop_when_empty_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && (count == '0)));

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Request-side controller for the 256x96 masked single-port SRAM macro (RW0 port).
// Optional post-reset zero sweep of the whole macro when SRAM_CTRL_INIT_CLEAR_EN is defined.
module sram_rw_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int  ADDR_W    = sram_ctrl_pkg::ADDR_W,
  parameter int  DATA_W    = sram_ctrl_pkg::DATA_W,
  parameter int  GRAN_W    = sram_ctrl_pkg::GRAN_W,
  parameter int  RSP_DEPTH = 2,
  localparam int MASK_W    = DATA_W / GRAN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic              req_fire_s;
  logic              rsp_fire_s;
  logic              rd_inflight_q, rd_inflight_d;
  logic              init_ready_s;
  logic              sweep_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W:0]    occ_s;

  assign rsp_valid  = (count_s != '0);
  assign rsp_fire_s = rsp_valid & rsp_ready;

  // Slots already owed to reads (queued + in flight), crediting a pop this cycle so a
  // draining consumer sustains one read per cycle through the rsp_ready->req_ready path.
  always_comb begin
    occ_s = {1'b0, count_s} + (CNT_W+1)'(rd_inflight_q) - (CNT_W+1)'(rsp_fire_s);
  end

  assign req_ready  = reset_n & init_ready_s & ~init_busy & (occ_s < (CNT_W+1)'(RSP_DEPTH));
  assign req_fire_s = req_valid & req_ready;

  always_comb begin
    rd_inflight_d = req_fire_s & ~req_write;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_inflight_q <= 1'b0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // The clear sweep owns the macro port while active; otherwise requests pass straight through.
  always_comb begin
    if (sweep_s) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = clr_addr_s;
      RW0_wmask = '1;
      RW0_wdata = '0;
    end else begin
      RW0_en    = req_fire_s;
      RW0_wmode = req_write;
      RW0_addr  = req_addr;
      RW0_wmask = req_write ? req_mask : '0;
      RW0_wdata = req_wdata;
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_inflight_q),
    .push_data (RW0_rdata),
    .pop       (rsp_fire_s),
    .pop_data  (rsp_rdata),
    .count     (count_s)
  );

`ifdef SRAM_CTRL_INIT_CLEAR_EN
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CLEAR = CLEAR;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]        init_state_q, init_state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              init_busy_q, init_busy_d;

  // IDLE lasts one cycle after reset so init_busy itself reads 0 while reset is held.
  always_comb begin
    init_state_d = init_state_q;
    clr_addr_d   = clr_addr_q;
    init_busy_d  = init_busy_q;
    case (init_state_q)
      ST_IDLE: begin
        init_state_d = ST_CLEAR;
        clr_addr_d   = '0;
        init_busy_d  = 1'b1;
      end
      ST_CLEAR: begin
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          init_state_d = ST_DONE;
          init_busy_d  = 1'b0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        init_busy_d = 1'b0;
      end
      default: begin
        init_state_d = ST_IDLE;
        init_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      init_state_q <= ST_IDLE;
      clr_addr_q   <= '0;
      init_busy_q  <= 1'b0;
    end else begin
      init_state_q <= init_state_d;
      clr_addr_q   <= clr_addr_d;
      init_busy_q  <= init_busy_d;
    end
  end

  assign sweep_s      = reset_n & (init_state_q == ST_CLEAR);
  assign clr_addr_s   = clr_addr_q;
  assign init_ready_s = (init_state_q == ST_DONE);
  assign init_busy    = init_busy_q;
`else
  assign sweep_s      = 1'b0;
  assign clr_addr_s   = '0;
  assign init_ready_s = 1'b1;
  assign init_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench for sram_rw_port_ctrl: behavioural SRAM macro plus a queue-based reference model.
module tb_sram_rw_port_ctrl;
  import sram_ctrl_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [95:0] PAT_A   = {24{4'hA}};
  localparam logic [95:0] PAT_MSK = 96'hFFFFFF_000000_FFFFFF_000000;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_busy;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en, RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  always #5 clock = ~clock;

  sram_rw_port_ctrl #(.RSP_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_busy(init_busy),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // Behavioural macro: masked write commits at the edge, read data appears the next cycle.
  logic [DATA_W-1:0] mac_mem [256];
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int g = 0; g < MASK_W; g++)
          if (RW0_wmask[g]) mac_mem[RW0_addr][g*GRAN_W +: GRAN_W] <= RW0_wdata[g*GRAN_W +: GRAN_W];
      end else begin
        RW0_rdata <= mac_mem[RW0_addr];
      end
    end
  end

  // Reference model: memory image plus queue of owed responses with the cycle they become visible.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic [DATA_W-1:0] ref_mem [256];
  exp_t              exp_q [$];
  int                cyc;
  int                n_checks, n_errors;
  int                obs_rsp, obs_acc;
  logic [DATA_W-1:0] last_rdata;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d, input logic rr);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_mask  = m;
    req_wdata = d;
    rsp_ready = rr;
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic exp_valid, exp_ready, pop_e, fire_e;
    @(negedge clock);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    pop_e     = exp_valid && rsp_ready;
    exp_ready = reset_n && ((exp_q.size() - (pop_e ? 1 : 0)) < DEPTH);
    fire_e    = req_valid && exp_ready;
    check_eq("req_ready", 96'(req_ready), 96'(exp_ready));
    check_eq("RW0_en", 96'(RW0_en), 96'(fire_e));
    check_eq("init_busy", 96'(init_busy), 96'(0));
    if (reset_n || exp_q.size() == 0) check_eq("rsp_valid", 96'(rsp_valid), 96'(exp_valid));
    if (reset_n && pop_e) check_eq("rsp_rdata", rsp_rdata, exp_q[0].data);
    if (fire_e) begin
      check_eq("RW0_wmode", 96'(RW0_wmode), 96'(req_write));
      check_eq("RW0_addr", 96'(RW0_addr), 96'(req_addr));
      check_eq("RW0_wmask", 96'(RW0_wmask), req_write ? 96'(req_mask) : 96'(0));
      if (req_write) check_eq("RW0_wdata", RW0_wdata, req_wdata);
    end
    if (reset_n && rsp_valid && rsp_ready) begin
      obs_rsp++;
      last_rdata = rsp_rdata;
    end
    if (reset_n && req_valid && req_ready) obs_acc++;
    @(posedge clock);
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (pop_e) void'(exp_q.pop_front());
      if (fire_e) begin
        if (req_write) begin
          for (int g = 0; g < MASK_W; g++)
            if (req_mask[g]) ref_mem[req_addr][g*GRAN_W +: GRAN_W] = req_wdata[g*GRAN_W +: GRAN_W];
        end else begin
          exp_q.push_back('{data: ref_mem[req_addr], due: cyc + 2});
        end
      end
    end
    cyc++;
    #1;
  endtask

`ifdef SRAM_CTRL_INIT_CLEAR_EN
  // Post-reset sweep: requests stay blocked, init_busy high for exactly one pass over memory.
  task automatic wait_init();
    int busy_n;
    bit seen;
    bit done;
    busy_n = 0;
    seen   = 1'b0;
    done   = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 4'h0, '0, 1'b1);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      if (seen && !init_busy) begin
        done = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1);
      end else begin
        check_eq("init_req_ready", 96'(req_ready), 96'(0));
        check_eq("init_rsp_valid", 96'(rsp_valid), 96'(0));
        if (init_busy) begin
          seen = 1'b1;
          busy_n++;
        end
      end
      @(posedge clock);
      cyc++;
      #1;
    end
    check_eq("init_busy_cycles", 96'(busy_n), 96'(256));
    for (int a = 0; a < 256; a++) ref_mem[a] = '0;
  endtask
`endif

  initial begin
    sram_req_t r;
    int        base;
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    obs_rsp    = 0;
    obs_acc    = 0;
    last_rdata = '0;
    RW0_rdata  = '0;
    for (int a = 0; a < 256; a++) begin
      mac_mem[a] = '0;
      ref_mem[a] = '0;
    end
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 4'h0, '0, 1'b1);
    @(posedge clock);
    #1;
    repeat (2) cycle();
    reset_n = 1'b1;
`ifdef SRAM_CTRL_INIT_CLEAR_EN
    wait_init();
`endif

    // Full write then read of the same word.
    drive(1'b1, 1'b1, 8'h10, 4'hF, PAT_A, 1'b1); cycle();
    drive(1'b1, 1'b0, 8'h10, 4'h0, '0, 1'b1);    cycle();
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1);    repeat (3) cycle();
    check_eq("t1_rdata", last_rdata, PAT_A);

    // Partial-mask overwrite, read immediately after the write.
    drive(1'b1, 1'b1, 8'h20, 4'hF, '1, 1'b1);    cycle();
    drive(1'b1, 1'b1, 8'h20, 4'h5, '0, 1'b1);    cycle();
    drive(1'b1, 1'b0, 8'h20, 4'h0, '0, 1'b1);    cycle();
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1);    repeat (3) cycle();
    check_eq("t2_rdata", last_rdata, PAT_MSK);

    // Back-to-back reads at full throughput.
    base = obs_rsp;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(i), 4'h0, '0, 1'b1);
      cycle();
    end
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1); repeat (3) cycle();
    check_eq("t3_rsp_count", 96'(obs_rsp - base), 96'(8));

    // Backpressure: only DEPTH reads accepted while the consumer stalls.
    base    = obs_rsp;
    obs_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i), 4'h0, '0, 1'b0);
      cycle();
    end
    check_eq("t4_accepted", 96'(obs_acc), 96'(DEPTH));
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1); repeat (4) cycle();
    check_eq("t4_rsp_count", 96'(obs_rsp - base), 96'(DEPTH));

    // Reset with one response queued and one read in flight.
    drive(1'b1, 1'b0, 8'h10, 4'h0, '0, 1'b0); repeat (2) cycle();
    base    = obs_rsp;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1); cycle();
    reset_n = 1'b1;
`ifdef SRAM_CTRL_INIT_CLEAR_EN
    wait_init();
`endif
    repeat (4) cycle();
    check_eq("t5_no_stale", 96'(obs_rsp - base), 96'(0));

`ifdef SRAM_CTRL_INIT_CLEAR_EN
    // Junk written before reset must be wiped by the sweep.
    drive(1'b1, 1'b1, 8'h00, 4'hF, '1, 1'b1); cycle();
    drive(1'b1, 1'b1, 8'hFF, 4'hF, '1, 1'b1); cycle();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1); cycle();
    reset_n = 1'b1;
    wait_init();
    last_rdata = '1;
    drive(1'b1, 1'b0, 8'h00, 4'h0, '0, 1'b1); cycle();
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1); repeat (3) cycle();
    check_eq("t6_rdata_00", last_rdata, '0);
    last_rdata = '1;
    drive(1'b1, 1'b0, 8'hFF, 4'h0, '0, 1'b1); cycle();
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1); repeat (3) cycle();
    check_eq("t6_rdata_ff", last_rdata, '0);
`endif

    // Randomised mix over a small address window to provoke read-after-write hazards.
    for (int i = 0; i < 1500; i++) begin
      r.write = 1'($urandom_range(0, 1));
      r.addr  = 8'($urandom_range(0, 15));
      r.mask  = 4'($urandom_range(0, 15));
      r.wdata = {$urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 3) != 0), r.write, r.addr, r.mask, r.wdata,
            1'($urandom_range(0, 3) != 0));
      cycle();
    end
    drive(1'b0, 1'b0, 8'h00, 4'h0, '0, 1'b1); repeat (6) cycle();
    check_eq("drain_empty", 96'(exp_q.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
